// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the PC / instruction-memory /
// register-file / ALU datapath. Steps each instruction through FETCH,
// DECODE, EXEC and WB, and gates the PC advance and the register-file
// read/write enables. Supports start/halt/clear control and counts retired
// instructions.
//
// Ports
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_start        level; leaves IDLE when high (clear has priority)
//   i_clear        level; leaves HALT to IDLE and clears status
//   i_instr        instruction word from instruction memory
//   i_imem_ready   instruction valid this cycle (sampled in FETCH)
//   o_imem_en      instruction-memory read enable (FETCH)
//   o_pc_en        one-cycle pulse, PC advances by 4 (WB)
//   o_rf_en        register-file read enable (EXEC, WB)
//   o_rf_we        register-file write enable (WB, legal, rd != 0)
//   o_alu_func     00 add, 01 sub, 10 and, 11 or
//   o_busy         high in FETCH/DECODE/EXEC/WB
//   o_halted       high in HALT
//   o_illegal      sticky: an unsupported instruction was decoded
//   o_instr_count  saturating count of retired instructions
module cpu_sequencer #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned MAX_INSTR = 0   // 0 = unlimited
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_clear,
    input  logic [31:0]      i_instr,
    input  logic             i_imem_ready,
    output logic             o_imem_en,
    output logic             o_pc_en,
    output logic             o_rf_en,
    output logic             o_rf_we,
    output logic [1:0]       o_alu_func,
    output logic             o_busy,
    output logic             o_halted,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_instr_count
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExec,
        StWb,
        StHalt
    } state_e;

    state_e            r_state, w_state_next;
    logic [31:0]       r_ir, w_ir_next;
    logic [1:0]        r_alu_func, w_alu_func_next;
    logic              r_legal, w_legal_next;
    logic              r_illegal, w_illegal_next;
    logic [CNT_W-1:0]  r_count, w_count_next;

    logic [5:0]        w_op;
    logic [5:0]        w_funct;
    logic [4:0]        w_rd;
    logic [CNT_W-1:0]  w_count_inc;
    logic              w_unused_ir;

    assign w_op    = r_ir[31:26];
    assign w_funct = r_ir[5:0];
    assign w_rd    = r_ir[15:11];

    // rs/rt/shamt are consumed by the datapath, not by the sequencer.
    assign w_unused_ir = ^{r_ir[25:16], r_ir[10:6]};

    // Saturate at all-ones rather than wrapping.
    assign w_count_inc = (&r_count) ? r_count : r_count + CNT_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_ir       <= '0;
            r_alu_func <= 2'b00;
            r_legal    <= 1'b0;
            r_illegal  <= 1'b0;
            r_count    <= '0;
        end else begin
            r_state    <= w_state_next;
            r_ir       <= w_ir_next;
            r_alu_func <= w_alu_func_next;
            r_legal    <= w_legal_next;
            r_illegal  <= w_illegal_next;
            r_count    <= w_count_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ir_next       = r_ir;
        w_alu_func_next = r_alu_func;
        w_legal_next    = r_legal;
        w_illegal_next  = r_illegal;
        w_count_next    = r_count;

        case (r_state)
            StIdle: begin
                if (i_start && !i_clear) begin
                    w_state_next = StFetch;
                end
            end

            StFetch: begin
                if (i_imem_ready) begin
                    w_ir_next    = i_instr;
                    w_state_next = StDecode;
                end
            end

            StDecode: begin
                if (w_op == 6'h3F) begin
                    w_state_next = StHalt;
                end else if (w_op == 6'h00 &&
                             (w_funct == 6'h20 || w_funct == 6'h22 ||
                              w_funct == 6'h24 || w_funct == 6'h25)) begin
                    case (w_funct)
                        6'h22:   w_alu_func_next = 2'b01;
                        6'h24:   w_alu_func_next = 2'b10;
                        6'h25:   w_alu_func_next = 2'b11;
                        default: w_alu_func_next = 2'b00;
                    endcase
                    w_legal_next = 1'b1;
                    w_state_next = StExec;
                end else begin
                    // Unsupported: skip EXEC and retire with writes suppressed.
                    w_legal_next   = 1'b0;
                    w_illegal_next = 1'b1;
                    w_state_next   = StWb;
                end
            end

            StExec: begin
                w_state_next = StWb;
            end

            StWb: begin
                w_count_next = w_count_inc;
                if (MAX_INSTR != 0 && w_count_inc == CNT_W'(MAX_INSTR)) begin
                    w_state_next = StHalt;
                end else begin
                    w_state_next = StFetch;
                end
            end

            StHalt: begin
                if (i_clear) begin
                    w_count_next   = '0;
                    w_illegal_next = 1'b0;
                    w_state_next   = StIdle;
                end
            end

            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Outputs decode registered state only.
    assign o_imem_en     = (r_state == StFetch);
    assign o_pc_en       = (r_state == StWb);
    assign o_rf_en       = (r_state == StExec) || (r_state == StWb);
    assign o_rf_we       = (r_state == StWb) && r_legal && (w_rd != 5'd0);
    assign o_alu_func    = r_alu_func;
    assign o_busy        = (r_state == StFetch) || (r_state == StDecode) ||
                           (r_state == StExec)  || (r_state == StWb);
    assign o_halted      = (r_state == StHalt);
    assign o_illegal     = r_illegal;
    assign o_instr_count = r_count;

endmodule
